control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 64 ++++++
 rtl/control_sequencer_if.sv | 25 ++
 rtl/control_sequencer_reg_decoder.sv | 15 +
 rtl/control_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer and datapath bench:
// opcodes, IR field positions, state encoding and the strobe bundle.
package control_sequencer_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_3REG, CLS_UNARY, CLS_MULDIV, CLS_HALT
  } op_class_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlo_out;
    logic zhi_out;
    logic lo_in;
    logic hi_in;
  } strobe_t;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_3REG;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction in, control strobes and
// one-hot register selects out.
interface control_sequencer_if #(parameter int NUM_REGS = 16);
  logic [31:0]         IR;
  logic                PCout, MARin, IncPC, PCin, Read, MDRin, MDRout;
  logic                IRin, Yin, Zin, ZLOout, ZHIout, Loin, HIin;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic [4:0]          ALU_opcode;
  logic                run;

  modport master (
    input  IR,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout,
    output IRin, Yin, Zin, ZLOout, ZHIout, Loin, HIin,
    output Rin, Rout, ALU_opcode, run
  );

  modport slave (
    output IR,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout,
    input  IRin, Yin, Zin, ZLOout, ZHIout, Loin, HIin,
    input  Rin, Rout, ALU_opcode, run
  );
endinterface

// File: rtl/control_sequencer_reg_decoder.sv
// 4-bit register index to one-hot select; indices beyond NUM_REGS decode to zero.
module reg_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (int'(idx) < NUM_REGS)) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired microsequencer: fetch (T0-T2), decode/execute (T3-T6), HALT.
// All outputs are flopped, decoded from the next state so they line up with state_q.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  state_e              state_q, state_d;
  strobe_t             stb_q, stb_d;
  logic [4:0]          alu_q, alu_d;
  logic                run_q, run_d;
  logic [NUM_REGS-1:0] rin_q, rin_d, rout_q, rout_d;
  logic                rin_en, rout_en;
  logic [3:0]          rin_idx, rout_idx;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  op_class_e  op_class;
  logic       ir_unused;

  assign opcode    = bus.IR[OPC_MSB:OPC_LSB];
  assign ra        = bus.IR[RA_MSB:RA_LSB];
  assign rb        = bus.IR[RB_MSB:RB_LSB];
  assign rc        = bus.IR[RC_MSB:RC_LSB];
  assign op_class  = classify(opcode);
  assign ir_unused = ^bus.IR[RC_LSB-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (op_class)
          CLS_HALT: state_d = S_HALT;
          CLS_NOP:  state_d = S_T0;
          default:  state_d = S_T4;
        endcase
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (op_class == CLS_MULDIV) ? S_T6 : S_T0;
      S_T6:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Decode outputs for the state being entered so the flops present them with it.
  always_comb begin
    stb_d    = '0;
    alu_d    = '0;
    run_d    = 1'b1;
    rin_en   = 1'b0;
    rin_idx  = ra;
    rout_en  = 1'b0;
    rout_idx = rb;
    case (state_d)
      S_T0: begin
        stb_d.pc_out = 1'b1;
        stb_d.mar_in = 1'b1;
        stb_d.inc_pc = 1'b1;
        stb_d.z_in   = 1'b1;
      end
      S_T1: begin
        stb_d.zlo_out = 1'b1;
        stb_d.pc_in   = 1'b1;
        stb_d.read    = 1'b1;
        stb_d.mdr_in  = 1'b1;
      end
      S_T2: begin
        stb_d.mdr_out = 1'b1;
        stb_d.ir_in   = 1'b1;
      end
      S_T3: begin
        if (op_class == CLS_3REG || op_class == CLS_MULDIV) begin
          rout_en    = 1'b1;
          rout_idx   = (op_class == CLS_MULDIV) ? ra : rb;
          stb_d.y_in = 1'b1;
        end
      end
      S_T4: begin
        rout_en    = 1'b1;
        rout_idx   = (op_class == CLS_3REG) ? rc : rb;
        stb_d.z_in = 1'b1;
        alu_d      = opcode;
      end
      S_T5: begin
        stb_d.zlo_out = 1'b1;
        if (op_class == CLS_MULDIV) stb_d.lo_in = 1'b1;
        else                        rin_en      = 1'b1;
      end
      S_T6: begin
        stb_d.zhi_out = 1'b1;
        stb_d.hi_in   = 1'b1;
      end
      S_HALT: run_d = 1'b0;
      default: ;
    endcase
  end

  reg_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec  (.idx(rin_idx),  .en(rin_en),  .onehot(rin_d));
  reg_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (.idx(rout_idx), .en(rout_en), .onehot(rout_d));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RST;
      stb_q   <= '0;
      alu_q   <= '0;
      run_q   <= 1'b1;
      rin_q   <= '0;
      rout_q  <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      alu_q   <= alu_d;
      run_q   <= run_d;
      rin_q   <= rin_d;
      rout_q  <= rout_d;
    end
  end

  assign bus.PCout      = stb_q.pc_out;
  assign bus.MARin      = stb_q.mar_in;
  assign bus.IncPC      = stb_q.inc_pc;
  assign bus.PCin       = stb_q.pc_in;
  assign bus.Read       = stb_q.read;
  assign bus.MDRin      = stb_q.mdr_in;
  assign bus.MDRout     = stb_q.mdr_out;
  assign bus.IRin       = stb_q.ir_in;
  assign bus.Yin        = stb_q.y_in;
  assign bus.Zin        = stb_q.z_in;
  assign bus.ZLOout     = stb_q.zlo_out;
  assign bus.ZHIout     = stb_q.zhi_out;
  assign bus.Loin       = stb_q.lo_in;
  assign bus.HIin       = stb_q.hi_in;
  assign bus.Rin        = rin_q;
  assign bus.Rout       = rout_q;
  assign bus.ALU_opcode = alu_q;
  assign bus.run        = run_q;

endmodule
